// File: rtl/pipe_controller.sv
// Pipelined RV32I control: decode in ID, control bundle carried through EX/MEM/WB.
// Define RV32M_EN to decode the M-extension (funct7=0000001 on OP) instead of flagging it illegal.
module pipe_controller #(
   parameter int CSR_EN    = 1,
   parameter int CNT_W     = 32,
   parameter int ALUCTRL_W = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 id_valid,
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic [6:0]           funct7,
   output logic [2:0]           imm_src_id,
   input  logic                 stall_i,
   input  logic                 flush_i,
   input  logic                 freeze_i,
   input  logic                 btaken_ex,
   output logic [ALUCTRL_W-1:0] alu_control_ex,
   output logic [1:0]           alusrc_a_ex,
   output logic                 alusrc_b_ex,
   output logic [1:0]           pcsrc_ex,
   output logic                 redirect_ex,
   output logic                 memwrite_m,
   output logic [2:0]           funct3_m,
   output logic                 regwrite_w,
   output logic [1:0]           resultsrc_w,
   output logic                 csr_w,
   output logic                 illegal_w,
   output logic [CNT_W-1:0]     instret
);

   if (ALUCTRL_W < 5) begin : g_alu_w_check
      $error("pipe_controller: ALUCTRL_W must be at least 5");
   end

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic       valid;
      logic [4:0] alu;
      logic [1:0] asrc_a;
      logic       asrc_b;
      logic       br;
      logic       jal;
      logic       jalr;
      logic       mw;
      logic [2:0] f3;
      logic       rw;
      logic [1:0] rs;
      logic       csr;
      logic       ill;
   } ex_t;

   typedef struct packed {
      logic       valid;
      logic       mw;
      logic [2:0] f3;
      logic       rw;
      logic [1:0] rs;
      logic       csr;
      logic       ill;
   } mem_t;

   typedef struct packed {
      logic       valid;
      logic       rw;
      logic [1:0] rs;
      logic       csr;
      logic       ill;
   } wb_t;

   ex_t  dec, ex;
   mem_t mem;
   wb_t  wb;
   logic legal;

   always_comb begin
      case (opcode)
         OP_STORE:          imm_src_id = 3'b001;
         OP_BRANCH:         imm_src_id = 3'b010;
         OP_JAL:            imm_src_id = 3'b011;
         OP_LUI, OP_AUIPC:  imm_src_id = 3'b100;
         default:           imm_src_id = 3'b000;
      endcase
   end

   always_comb begin
      dec   = '0;
      legal = 1'b1;
      case (opcode)
         OP_R: begin
            dec.rw = 1'b1;
            if (funct7 == 7'b0000000)
               dec.alu = {2'b00, funct3};
            else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
               dec.alu = {2'b01, funct3};
`ifdef RV32M_EN
            else if (funct7 == 7'b0000001)
               dec.alu = {2'b10, funct3};
`endif
            else
               legal = 1'b0;
         end
         OP_I: begin
            dec.rw     = 1'b1;
            dec.asrc_b = 1'b1;
            dec.alu    = (funct3 == 3'b101 && funct7 == 7'b0100000) ? 5'b01101 : {2'b00, funct3};
         end
         OP_LOAD: begin
            dec.rw     = 1'b1;
            dec.asrc_b = 1'b1;
            dec.rs     = 2'b01;
         end
         OP_STORE: begin
            dec.asrc_b = 1'b1;
            dec.mw     = 1'b1;
         end
         OP_BRANCH: begin
            dec.br  = 1'b1;
            dec.alu = {2'b11, funct3};
            legal   = (funct3[2:1] != 2'b01);
         end
         OP_JAL: begin
            dec.jal    = 1'b1;
            dec.asrc_a = 2'b01;
            dec.asrc_b = 1'b1;
            dec.rw     = 1'b1;
            dec.rs     = 2'b10;
         end
         OP_JALR: begin
            dec.jalr   = 1'b1;
            dec.asrc_b = 1'b1;
            dec.rw     = 1'b1;
            dec.rs     = 2'b10;
         end
         OP_LUI: begin
            dec.alu    = 5'b11010;
            dec.asrc_a = 2'b10;
            dec.asrc_b = 1'b1;
            dec.rw     = 1'b1;
         end
         OP_AUIPC: begin
            dec.asrc_a = 2'b01;
            dec.asrc_b = 1'b1;
            dec.rw     = 1'b1;
         end
         OP_SYSTEM: begin
            if (CSR_EN != 0) begin
               dec.csr = 1'b1;
               dec.rw  = 1'b1;
               dec.rs  = 2'b11;
            end else begin
               legal = 1'b0;
            end
         end
         default: legal = 1'b0;
      endcase
      // Illegal instructions travel as valid with only the flag and access size kept.
      if (!legal) begin
         dec     = '0;
         dec.ill = 1'b1;
      end
      dec.f3    = funct3;
      dec.valid = 1'b1;
      if (!id_valid) dec = '0;
   end

   always_comb begin
      pcsrc_ex = 2'b00;
      if (ex.valid) begin
         if (ex.jalr)
            pcsrc_ex = 2'b10;
         else if ((ex.br && btaken_ex) || ex.jal)
            pcsrc_ex = 2'b01;
      end
   end

   assign redirect_ex = (pcsrc_ex != 2'b00) && !freeze_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex      <= '0;
         mem     <= '0;
         wb      <= '0;
         instret <= '0;
      end else if (!freeze_i) begin
         if (wb.valid && !wb.ill) instret <= instret + CNT_W'(1);
         wb  <= '{valid: mem.valid, rw: mem.rw, rs: mem.rs, csr: mem.csr, ill: mem.ill};
         mem <= '{valid: ex.valid, mw: ex.mw, f3: ex.f3, rw: ex.rw, rs: ex.rs, csr: ex.csr, ill: ex.ill};
         ex  <= (flush_i || redirect_ex || stall_i) ? '0 : dec;
      end
   end

   assign alu_control_ex = ALUCTRL_W'(ex.alu);
   assign alusrc_a_ex    = ex.asrc_a;
   assign alusrc_b_ex    = ex.asrc_b;
   assign memwrite_m     = mem.mw;
   assign funct3_m       = mem.f3;
   assign regwrite_w     = wb.rw;
   assign resultsrc_w    = wb.rs;
   assign csr_w          = wb.csr;
   assign illegal_w      = wb.ill;

endmodule

// File: tb/tb_pipe_controller.sv
// Self-checking bench for pipe_controller: directed vector table, corner sequences, random vs. pipeline model.
module tb_pipe_controller;
   localparam int CNT_W = 4;
`ifdef RV32M_EN
   localparam bit M_EN = 1'b1;
`else
   localparam bit M_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic id_valid, stall_i, flush_i, freeze_i, btaken_ex;
   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic [2:0] imm_src_id;
   logic [4:0] alu_control_ex;
   logic [1:0] alusrc_a_ex, pcsrc_ex, resultsrc_w;
   logic alusrc_b_ex, redirect_ex, memwrite_m, regwrite_w, csr_w, illegal_w;
   logic [2:0] funct3_m;
   logic [CNT_W-1:0] instret;

   always #5 clk = ~clk;

   pipe_controller #(.CSR_EN(1), .CNT_W(CNT_W), .ALUCTRL_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .funct3(funct3),
      .funct7(funct7), .imm_src_id(imm_src_id), .stall_i(stall_i), .flush_i(flush_i),
      .freeze_i(freeze_i), .btaken_ex(btaken_ex), .alu_control_ex(alu_control_ex),
      .alusrc_a_ex(alusrc_a_ex), .alusrc_b_ex(alusrc_b_ex), .pcsrc_ex(pcsrc_ex),
      .redirect_ex(redirect_ex), .memwrite_m(memwrite_m), .funct3_m(funct3_m),
      .regwrite_w(regwrite_w), .resultsrc_w(resultsrc_w), .csr_w(csr_w),
      .illegal_w(illegal_w), .instret(instret));

   typedef struct packed {
      logic v; logic [4:0] alu; logic [1:0] a; logic b; logic br, jal, jalr, mw;
      logic [2:0] f3; logic rw; logic [1:0] rs; logic csr, ill;
   } ctl_t;

   // p[0]=EX, p[1]=MEM, p[2]=WB
   ctl_t p [3];
   int unsigned m_cnt;
   int errors = 0, checks = 0;

   typedef struct {
      logic v; logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic st, fl, fr, bt;
      logic [4:0] e_alu; logic e_b; logic [1:0] e_pc; logic e_rd; logic e_rw;
      logic [1:0] e_rs; logic e_ill; logic [3:0] e_cnt;
   } vec_t;
   vec_t tbl [14];

   function automatic ctl_t ref_decode(logic v, logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
      ctl_t c = '0;
      bit ok = 1'b1;
      if (!v) return c;
      case (op)
         7'h33: begin
            c.rw = 1;
            if (f7 == 7'h00) c.alu = {2'b00, f3};
            else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) c.alu = {2'b01, f3};
            else if (f7 == 7'h01 && M_EN) c.alu = {2'b10, f3};
            else ok = 0;
         end
         7'h13: begin c.rw = 1; c.b = 1; c.alu = (f3 == 5 && f7 == 7'h20) ? 5'd13 : {2'b00, f3}; end
         7'h03: begin c.rw = 1; c.b = 1; c.rs = 1; end
         7'h23: begin c.b = 1; c.mw = 1; end
         7'h63: begin c.br = 1; c.alu = {2'b11, f3}; ok = !(f3 == 2 || f3 == 3); end
         7'h6F: begin c.jal = 1; c.a = 1; c.b = 1; c.rw = 1; c.rs = 2; end
         7'h67: begin c.jalr = 1; c.b = 1; c.rw = 1; c.rs = 2; end
         7'h37: begin c.alu = 5'd26; c.a = 2; c.b = 1; c.rw = 1; end
         7'h17: begin c.a = 1; c.b = 1; c.rw = 1; end
         7'h73: begin c.csr = 1; c.rw = 1; c.rs = 3; end
         default: ok = 0;
      endcase
      if (!ok) begin c = '0; c.ill = 1; end
      c.v = 1; c.f3 = f3;
      return c;
   endfunction

   function automatic logic [2:0] ref_imm(logic [6:0] op);
      case (op)
         7'h23: return 3'd1;
         7'h63: return 3'd2;
         7'h6F: return 3'd3;
         7'h37, 7'h17: return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic [1:0] ref_pcsrc();
      if (!p[0].v) return 2'd0;
      if (p[0].jalr) return 2'd2;
      if ((p[0].br && btaken_ex) || p[0].jal) return 2'd1;
      return 2'd0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_model();
      logic [1:0] pc;
      pc = ref_pcsrc();
      chk("imm_src_id", imm_src_id, ref_imm(opcode));
      chk("alu_control_ex", alu_control_ex, p[0].alu);
      chk("alusrc_a_ex", alusrc_a_ex, p[0].a);
      chk("alusrc_b_ex", alusrc_b_ex, p[0].b);
      chk("pcsrc_ex", pcsrc_ex, pc);
      chk("redirect_ex", redirect_ex, (pc != 0) && !freeze_i);
      chk("memwrite_m", memwrite_m, p[1].mw);
      chk("funct3_m", funct3_m, p[1].f3);
      chk("regwrite_w", regwrite_w, p[2].rw);
      chk("resultsrc_w", resultsrc_w, p[2].rs);
      chk("csr_w", csr_w, p[2].csr);
      chk("illegal_w", illegal_w, p[2].ill);
      chk("instret", instret, m_cnt % (1 << CNT_W));
   endtask

   task automatic model_step();
      bit squash;
      if (freeze_i) return;
      squash = flush_i || stall_i || (ref_pcsrc() != 0);
      if (p[2].v && !p[2].ill) m_cnt++;
      p[2] = p[1];
      p[1] = p[0];
      p[0] = squash ? ctl_t'('0) : ref_decode(id_valid, opcode, funct3, funct7);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 3; i++) p[i] = '0;
      m_cnt = 0;
   endtask

   task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic st, input logic fl, input logic fr, input logic bt);
      @(negedge clk);
      id_valid = v; opcode = op; funct3 = f3; funct7 = f7;
      stall_i = st; flush_i = fl; freeze_i = fr; btaken_ex = bt;
      #1;
   endtask

   task automatic adv();
      @(posedge clk);
      model_step();
   endtask

   task automatic step(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic st, input logic fl, input logic fr, input logic bt);
      drive(v, op, f3, f7, st, fl, fr, bt);
      check_model();
      adv();
   endtask

   task automatic idle_inputs();
      id_valid = 0; opcode = 0; funct3 = 0; funct7 = 0;
      stall_i = 0; flush_i = 0; freeze_i = 0; btaken_ex = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_alu"}, alu_control_ex, 0);
      chk({tag, "_pcsrc"}, pcsrc_ex, 0);
      chk({tag, "_redirect"}, redirect_ex, 0);
      chk({tag, "_memwrite"}, memwrite_m, 0);
      chk({tag, "_regwrite"}, regwrite_w, 0);
      chk({tag, "_resultsrc"}, resultsrc_w, 0);
      chk({tag, "_illegal"}, illegal_w, 0);
      chk({tag, "_instret"}, instret, 0);
   endtask

   initial begin
      // ADD, SUB, BEQ taken (squashes LW), bubble with btaken, BEQ not taken, illegal, LW + stall
      tbl[0]  = '{1, 7'h33, 0, 7'h00, 0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 7'h33, 0, 7'h20, 0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 0, 0, 0};
      tbl[2]  = '{1, 7'h63, 0, 7'h00, 0, 0, 0, 0, 5'd8,  0, 0, 0, 0, 0, 0, 0};
      tbl[3]  = '{1, 7'h03, 2, 7'h00, 0, 0, 0, 1, 5'd24, 0, 1, 1, 1, 0, 0, 0};
      tbl[4]  = '{0, 7'h00, 0, 7'h00, 0, 0, 0, 1, 5'd0,  0, 0, 0, 1, 0, 0, 1};
      tbl[5]  = '{1, 7'h63, 0, 7'h00, 0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 0, 0, 2};
      tbl[6]  = '{0, 7'h00, 0, 7'h00, 0, 0, 0, 0, 5'd24, 0, 0, 0, 0, 0, 0, 3};
      tbl[7]  = '{1, 7'h00, 0, 7'h00, 0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 0, 0, 3};
      tbl[8]  = '{0, 7'h00, 0, 7'h00, 0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 0, 0, 3};
      tbl[9]  = '{1, 7'h03, 2, 7'h00, 0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 0, 0, 4};
      tbl[10] = '{1, 7'h33, 0, 7'h00, 1, 0, 0, 0, 5'd0,  1, 0, 0, 0, 0, 1, 4};
      tbl[11] = '{0, 7'h00, 0, 7'h00, 0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 0, 0, 4};
      tbl[12] = '{0, 7'h00, 0, 7'h00, 0, 0, 0, 0, 5'd0,  0, 0, 0, 1, 1, 0, 4};
      tbl[13] = '{0, 7'h00, 0, 7'h00, 0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 0, 0, 5};

      rst_n = 0;
      idle_inputs();
      model_clear();
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1;

      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].v, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].st, tbl[i].fl, tbl[i].fr, tbl[i].bt);
         check_model();
         chk($sformatf("vec%0d_alu", i), alu_control_ex, tbl[i].e_alu);
         chk($sformatf("vec%0d_alusrc_b", i), alusrc_b_ex, tbl[i].e_b);
         chk($sformatf("vec%0d_pcsrc", i), pcsrc_ex, tbl[i].e_pc);
         chk($sformatf("vec%0d_redirect", i), redirect_ex, tbl[i].e_rd);
         chk($sformatf("vec%0d_regwrite", i), regwrite_w, tbl[i].e_rw);
         chk($sformatf("vec%0d_resultsrc", i), resultsrc_w, tbl[i].e_rs);
         chk($sformatf("vec%0d_illegal", i), illegal_w, tbl[i].e_ill);
         chk($sformatf("vec%0d_instret", i), instret, tbl[i].e_cnt);
         adv();
      end

      // JALR held in EX by freeze, then redirects and squashes the SUB behind it
      step(1, 7'h67, 0, 7'h00, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         drive(1, 7'h33, 0, 7'h20, 0, 0, 1, 0);
         check_model();
         chk("freeze_redirect", redirect_ex, 0);
         chk("freeze_pcsrc", pcsrc_ex, 2);
         chk("freeze_alusrc_b", alusrc_b_ex, 1);
         adv();
      end
      drive(1, 7'h33, 0, 7'h20, 0, 0, 0, 0);
      check_model();
      chk("release_redirect", redirect_ex, 1);
      chk("release_pcsrc", pcsrc_ex, 2);
      adv();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check_model();
      chk("release_bubble_alu", alu_control_ex, 0);
      adv();

      // M-extension encoding
      step(1, 7'h33, 0, 7'h01, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check_model();
      chk("mul_alu", alu_control_ex, M_EN ? 32'd16 : 32'd0);
      adv();
      step(0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check_model();
      chk("mul_illegal", illegal_w, !M_EN);
      chk("mul_regwrite", regwrite_w, M_EN);
      adv();

      // Asynchronous reset in the middle of a clock phase
      for (int k = 0; k < 4; k++) step(1, 7'h33, 0, 7'h00, 0, 0, 0, 0);
      #2;
      idle_inputs();
      chk("pre_reset_regwrite", regwrite_w, 1);
      rst_n = 0;
      #1;
      chk_zero("midreset");
      model_clear();
      @(negedge clk);
      rst_n = 1;

      // 17 retirements on a 4-bit counter wrap to 1
      for (int k = 0; k < 17; k++) step(1, 7'h33, 0, 7'h00, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check_model();
      chk("wrap_instret", instret, 1);
      adv();

      for (int i = 0; i < 3000; i++) begin
         logic [6:0] op, f7;
         logic [3:0] sel;
         sel = 4'($urandom_range(0, 11));
         case (sel)
            0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h03;  3: op = 7'h23;
            4: op = 7'h63;  5: op = 7'h6F;  6: op = 7'h67;  7: op = 7'h37;
            8: op = 7'h17;  9: op = 7'h73;  10: op = 7'h33;
            default: op = 7'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom);
         endcase
         step($urandom_range(0, 9) != 0, op, 3'($urandom), f7,
              $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0,
              $urandom_range(0, 7) == 0, 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
